// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the instruction fetch path: FSM states, next-PC
// select codes and the default halt opcode.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

    // A fetch address is usable only if word aligned and inside the ROM.
    function automatic logic addr_in_rom(input logic [31:0] addr, input logic [31:0] rom_bytes);
        return (addr[1:0] == 2'b00) && (addr < rom_bytes);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or J-type jump.
module next_pc_calc
    import cpu_defs_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jump_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;

    assign pc4 = pc + 32'd4;

    always_comb begin
        next_pc = pc4;
        case (pc_src)
            PCSRC_BR: next_pc = pc4 + (imm_ext << 2);
            PCSRC_J:  next_pc = {pc4[31:28], jump_target, 2'b00};
            default:  next_pc = pc4;    // reserved code behaves as sequential
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address and stops on the
// halt opcode or on an unusable next fetch address.
module pc_fetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned ROM_WORDS   = 20,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] immExt,
    input  logic [25:0] jumpTarget,
    input  logic [31:0] instruction,
    output logic [31:0] romAddr,
    output logic [31:0] curPC,
    output logic [31:0] nextPC,
    output logic        PCWre,
    output logic [1:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retireCnt
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [15:0]  cnt_reg, cnt_next;
    logic         halted_reg, fault_reg;
    logic         pc_we;
    logic [31:0]  cand_pc;

    next_pc_calc u_next_pc (
        .pc          (pc_reg),
        .pc_src      (PCSrc),
        .imm_ext     (immExt),
        .jump_target (jumpTarget),
        .next_pc     (cand_pc)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        pc_we      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                // Halt beats stall, and a stalled cycle never faults.
                if (instruction[31:26] == HALT_OPCODE) begin
                    state_next = ST_HALT;
                end else if (stall) begin
                    state_next = ST_RUN;
                end else if (!addr_in_rom(cand_pc, ROM_BYTES)) begin
                    state_next = ST_FAULT;
                end else begin
                    pc_we   = 1'b1;
                    pc_next = cand_pc;
                    if (cnt_reg != 16'hFFFF) cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    cnt_next   = 16'd0;
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            cnt_reg    <= 16'd0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            cnt_reg    <= cnt_next;
            halted_reg <= (state_next == ST_HALT);
            fault_reg  <= (state_next == ST_FAULT);
        end
    end

    assign romAddr   = pc_reg;
    assign curPC     = pc_reg;
    assign nextPC    = cand_pc;
    assign PCWre     = pc_we;
    assign state     = state_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;
    assign retireCnt = cnt_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pc_fetch_ctrl;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic        stall;
    logic [1:0]  PCSrc;
    logic [31:0] immExt;
    logic [25:0] jumpTarget;
    logic [31:0] instruction;
    logic [31:0] romAddr;
    logic [31:0] curPC;
    logic [31:0] nextPC;
    logic        PCWre;
    logic [1:0]  state;
    logic        halted;
    logic        fault;
    logic [15:0] retireCnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nxt;
        logic        we;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    pc_fetch_ctrl #(
        .ROM_WORDS   (20),
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .start       (start),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .immExt      (immExt),
        .jumpTarget  (jumpTarget),
        .instruction (instruction),
        .romAddr     (romAddr),
        .curPC       (curPC),
        .nextPC      (nextPC),
        .PCWre       (PCWre),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .retireCnt   (retireCnt)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            txn++;
            if (romAddr !== mon_e.addr || curPC !== mon_e.addr || nextPC !== mon_e.nxt ||
                PCWre !== mon_e.we || state !== mon_e.st ||
                halted !== (mon_e.st == S_HALT) || fault !== (mon_e.st == S_FAULT) ||
                retireCnt !== mon_e.cnt) begin
                errors++;
                $display("FAIL txn%0d got addr=%0d pc=%0d next=%0d we=%0b st=%0d h=%0b f=%0b cnt=%0d want addr=%0d next=%0d we=%0b st=%0d cnt=%0d",
                         txn, romAddr, curPC, nextPC, PCWre, state, halted, fault, retireCnt,
                         mon_e.addr, mon_e.nxt, mon_e.we, mon_e.st, mon_e.cnt);
            end else begin
                $display("txn%0d ok addr=%0d next=%0d we=%0b st=%0d cnt=%0d",
                         txn, romAddr, nextPC, PCWre, state, retireCnt);
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] n, input logic w,
                            input logic [1:0] s, input logic [15:0] c);
        exp_t e;
        e.addr = a; e.nxt = n; e.we = w; e.st = s; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs, record what the DUT must show this cycle, advance.
    task automatic step(input logic st_i, input logic sl_i, input logic [1:0] src_i,
                        input logic [31:0] imm_i, input logic [25:0] jt_i, input logic [31:0] ins_i,
                        input logic [31:0] e_addr, input logic [31:0] e_next, input logic e_we,
                        input logic [1:0] e_st, input logic [15:0] e_cnt);
        start = st_i; stall = sl_i; PCSrc = src_i;
        immExt = imm_i; jumpTarget = jt_i; instruction = ins_i;
        push_exp(e_addr, e_next, e_we, e_st, e_cnt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; stall = 1'b0; PCSrc = 2'b00;
        immExt = '0; jumpTarget = '0; instruction = '0;
        #12 Reset = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state, then sequential run to the end of the ROM
        step(0, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_IDLE, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_IDLE, 0);
        for (int i = 0; i < 19; i++)
            step(0, 0, 2'b00, 0, 0, 0, 32'(4 * i), 32'(4 * i + 4), 1, S_RUN, 16'(i));
        step(0, 1, 2'b00, 0, 0, 0, 76, 80, 0, S_RUN, 19);
        step(0, 1, 2'b00, 0, 0, 0, 76, 80, 0, S_RUN, 19);
        step(0, 0, 2'b00, 0, 0, 0, 76, 80, 0, S_RUN, 19);
        step(0, 0, 2'b00, 0, 0, 0, 76, 80, 0, S_FAULT, 19);
        step(1, 0, 2'b00, 0, 0, 0, 76, 80, 0, S_FAULT, 19);

        // Branch and jump
        step(0, 0, 2'b00, 0, 0, 0, 0, 4, 1, S_RUN, 0);
        step(0, 0, 2'b00, 0, 0, 0, 4, 8, 1, S_RUN, 1);
        step(0, 0, 2'b01, 32'hFFFF_FFFE, 0, 0, 8, 4, 1, S_RUN, 2);
        step(0, 0, 2'b10, 0, 26'd5, 0, 4, 20, 1, S_RUN, 3);
        step(0, 0, 2'b01, 32'hFFFF_FFFD, 0, 0, 20, 12, 1, S_RUN, 4);

        // Stall at 12, then resume and hit the halt opcode at 24
        for (int i = 0; i < 3; i++)
            step(0, 1, 2'b00, 0, 0, 0, 12, 16, 0, S_RUN, 5);
        step(0, 0, 2'b00, 0, 0, 0, 12, 16, 1, S_RUN, 5);
        step(0, 0, 2'b00, 0, 0, 0, 16, 20, 1, S_RUN, 6);
        step(0, 0, 2'b00, 0, 0, 0, 20, 24, 1, S_RUN, 7);
        step(0, 1, 2'b00, 0, 0, 32'hFC00_0000, 24, 28, 0, S_RUN, 8);
        step(0, 1, 2'b10, 0, 26'd3, 0, 24, 12, 0, S_HALT, 8);
        step(1, 0, 2'b00, 0, 0, 0, 24, 28, 0, S_HALT, 8);

        // Jump past the ROM faults; jump/branch onto the last word is legal
        step(0, 0, 2'b10, 0, 26'd20, 0, 0, 80, 0, S_RUN, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_FAULT, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_FAULT, 0);
        step(0, 0, 2'b10, 0, 26'd19, 0, 0, 76, 1, S_RUN, 0);
        step(0, 0, 2'b01, 32'hFFFF_FFFF, 0, 0, 76, 76, 1, S_RUN, 1);
        step(0, 0, 2'b01, 32'd100, 0, 0, 76, 480, 0, S_RUN, 2);
        step(0, 0, 2'b00, 0, 0, 0, 76, 80, 0, S_FAULT, 2);
        step(1, 0, 2'b00, 0, 0, 0, 76, 80, 0, S_FAULT, 2);

        // Asynchronous reset between edges at PC 40
        for (int i = 0; i < 10; i++)
            step(0, 0, 2'b00, 0, 0, 0, 32'(4 * i), 32'(4 * i + 4), 1, S_RUN, 16'(i));
        #2;
        Reset = 1'b1;
        push_exp(0, 4, 0, S_IDLE, 0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        step(0, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_IDLE, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 4, 0, S_IDLE, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 4, 1, S_RUN, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
